// File: rtl/startup_sequencer.sv
// startup_sequencer: releases stage enables one at a time with gap, ready handshake, timeout and ready-loss fault
module startup_sequencer #(
  parameter int N_STAGES      = 4,
  parameter int IDX_W         = 2,
  parameter int CNT_W         = 32,
  parameter int STAGE_GAP     = 80000,
  parameter int READY_TIMEOUT = 800000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N_STAGES-1:0] ready,
  output logic [N_STAGES-1:0] en,
  output logic                busy,
  output logic                done,
  output logic                fault,
  output logic [IDX_W-1:0]    fault_stage
);
  typedef enum logic [2:0] {IDLE, GAP, WAIT_RDY, DONE, FAULT} state_t;
  state_t state, state_n;
  logic [IDX_W-1:0] stage, stage_n, fstage_n, lost_idx;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [N_STAGES-1:0] en_n, lost;
  always_comb begin
    lost = '0;
    lost_idx = '0;
    for (int j = 0; j < N_STAGES; j++)
      lost[j] = !ready[j] && (state == DONE || ((state == GAP || state == WAIT_RDY) && IDX_W'(j) < stage));
    for (int j = N_STAGES - 1; j >= 0; j--)
      if (lost[j]) lost_idx = IDX_W'(j);
  end
  always_comb begin
    state_n = state;
    stage_n = stage;
    cnt_n = cnt;
    en_n = en;
    fstage_n = fault_stage;
    if (state != IDLE && !start) begin
      state_n = IDLE;
      stage_n = '0;
      cnt_n = '0;
      en_n = '0;
      fstage_n = '0;
    end else if (|lost) begin
      state_n = FAULT;
      cnt_n = '0;
      en_n = '0;
      fstage_n = lost_idx;
    end else begin
      case (state)
        IDLE: if (start) begin
          state_n = GAP;
          stage_n = '0;
          cnt_n = '0;
        end
        GAP: if (cnt == CNT_W'(STAGE_GAP - 1)) begin
          state_n = WAIT_RDY;
          en_n[stage] = 1'b1;
          cnt_n = '0;
        end else cnt_n = cnt + 1'b1;
        WAIT_RDY: if (ready[stage]) begin
          cnt_n = '0;
          state_n = (stage == IDX_W'(N_STAGES - 1)) ? DONE : GAP;
          stage_n = (stage == IDX_W'(N_STAGES - 1)) ? stage : stage + 1'b1;
        end else if (cnt == CNT_W'(READY_TIMEOUT - 1)) begin
          state_n = FAULT;
          cnt_n = '0;
          en_n = '0;
          fstage_n = stage;
        end else cnt_n = cnt + 1'b1;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      stage <= '0;
      cnt <= '0;
      en <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      fault <= 1'b0;
      fault_stage <= '0;
    end else begin
      state <= state_n;
      stage <= stage_n;
      cnt <= cnt_n;
      en <= en_n;
      busy <= state_n == GAP || state_n == WAIT_RDY;
      done <= state_n == DONE;
      fault <= state_n == FAULT;
      fault_stage <= fstage_n;
    end
  end
endmodule

// File: tb/tb_startup_sequencer.sv
// tb_startup_sequencer: table-driven scoreboard bench for startup_sequencer
module tb_startup_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0] ready = '0;
  logic [3:0] en;
  logic busy, done, fault;
  logic [1:0] fault_stage;
  startup_sequencer #(.N_STAGES(4), .IDX_W(2), .CNT_W(32), .STAGE_GAP(4), .READY_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .en(en),
    .busy(busy), .done(done), .fault(fault), .fault_stage(fault_stage)
  );
  always #5 clk = ~clk;
  typedef struct {
    int t;
    logic [3:0] rdy;
    logic [8:0] exp;
  } vec_t;
  vec_t vq[$];
  logic [8:0] sb[$];
  int tests = 0, fails = 0, cur = 0;
  task automatic step();
    @(posedge clk);
    #1;
    cur++;
  endtask
  task automatic add(input int t, input logic [3:0] r, input logic [3:0] e, input logic b, input logic d, input logic f, input logic [1:0] fs);
    vq.push_back('{t, r, {e, b, d, f, fs}});
  endtask
  task automatic check(input string name);
    logic [8:0] a, e;
    a = {en, busy, done, fault, fault_stage};
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s t=%0d: scoreboard empty, got %b", name, cur, a);
    end else begin
      e = sb.pop_front();
      if (a !== e) begin
        fails++;
        $display("FAIL %s t=%0d: got {en,busy,done,fault,fs}=%b want %b", name, cur, a, e);
      end
    end
  endtask
  task automatic run(input string name);
    foreach (vq[i]) begin
      sb.push_back(vq[i].exp);
      while (cur < vq[i].t) step();
      check(name);
      ready = vq[i].rdy;
    end
    vq.delete();
  endtask
  task automatic begin_seq();
    rst = 1'b0;
    start = 1'b0;
    ready = '0;
    step();
    step();
    start = 1'b1;
    step();
    cur = 0;
  endtask
  initial begin
    start = 1'b1;
    ready = 4'b1111;
    step();
    step();
    cur = 0;
    add(0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    run("reset");
    begin_seq();
    add(0, 4'b0000, 4'b0000, 1, 0, 0, 0);
    add(3, 4'b0000, 4'b0000, 1, 0, 0, 0);
    add(4, 4'b0000, 4'b0001, 1, 0, 0, 0);
    add(5, 4'b0001, 4'b0001, 1, 0, 0, 0);
    add(6, 4'b0001, 4'b0001, 1, 0, 0, 0);
    add(9, 4'b0001, 4'b0001, 1, 0, 0, 0);
    add(10, 4'b0001, 4'b0011, 1, 0, 0, 0);
    add(11, 4'b0011, 4'b0011, 1, 0, 0, 0);
    add(16, 4'b0011, 4'b0111, 1, 0, 0, 0);
    add(17, 4'b0111, 4'b0111, 1, 0, 0, 0);
    add(22, 4'b0111, 4'b1111, 1, 0, 0, 0);
    add(23, 4'b1111, 4'b1111, 1, 0, 0, 0);
    add(24, 4'b1111, 4'b1111, 0, 1, 0, 0);
    add(26, 4'b1111, 4'b1111, 0, 1, 0, 0);
    run("full_seq");
    begin_seq();
    add(4, 4'b0000, 4'b0001, 1, 0, 0, 0);
    add(5, 4'b0001, 4'b0001, 1, 0, 0, 0);
    add(10, 4'b0001, 4'b0011, 1, 0, 0, 0);
    add(17, 4'b0001, 4'b0011, 1, 0, 0, 0);
    add(18, 4'b0001, 4'b0000, 0, 0, 1, 1);
    add(21, 4'b0001, 4'b0000, 0, 0, 1, 1);
    run("timeout");
    begin_seq();
    add(5, 4'b0001, 4'b0001, 1, 0, 0, 0);
    add(11, 4'b0011, 4'b0011, 1, 0, 0, 0);
    add(16, 4'b0011, 4'b0111, 1, 0, 0, 0);
    add(23, 4'b0111, 4'b0111, 1, 0, 0, 0);
    add(24, 4'b0111, 4'b0111, 1, 0, 0, 0);
    add(28, 4'b0111, 4'b1111, 1, 0, 0, 0);
    add(29, 4'b1111, 4'b1111, 1, 0, 0, 0);
    add(30, 4'b1111, 4'b1111, 0, 1, 0, 0);
    run("late_ready");
    add(31, 4'b0110, 4'b1111, 0, 1, 0, 0);
    add(32, 4'b0110, 4'b0000, 0, 0, 1, 0);
    add(34, 4'b0110, 4'b0000, 0, 0, 1, 0);
    run("ready_loss");
    begin_seq();
    add(5, 4'b0001, 4'b0001, 1, 0, 0, 0);
    add(11, 4'b0011, 4'b0011, 1, 0, 0, 0);
    add(13, 4'b0011, 4'b0011, 1, 0, 0, 0);
    run("mid_gap");
    start = 1'b0;
    add(14, 4'b0000, 4'b0000, 0, 0, 0, 0);
    run("stop");
    start = 1'b1;
    add(15, 4'b0000, 4'b0000, 1, 0, 0, 0);
    add(18, 4'b0000, 4'b0000, 1, 0, 0, 0);
    add(19, 4'b0000, 4'b0001, 1, 0, 0, 0);
    run("restart");
    begin_seq();
    add(5, 4'b0000, 4'b0001, 1, 0, 0, 0);
    run("pre_rst_wait");
    rst = 1'b1;
    add(6, 4'b0000, 4'b0000, 0, 0, 0, 0);
    run("rst_wait");
    rst = 1'b0;
    start = 1'b0;
    add(9, 4'b0000, 4'b0000, 0, 0, 0, 0);
    run("idle_hold");
    begin_seq();
    add(12, 4'b0000, 4'b0000, 0, 0, 1, 0);
    run("pre_rst_fault");
    rst = 1'b1;
    add(13, 4'b0000, 4'b0000, 0, 0, 0, 0);
    run("rst_fault");
    rst = 1'b0;
    start = 1'b0;
    add(16, 4'b0000, 4'b0000, 0, 0, 0, 0);
    run("idle_hold2");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
